// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, FSM
// encoding and small bit-level helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic int cnt_width(input int period);
    if (period > 1) begin
      return $clog2(period);
    end else begin
      return 1;
    end
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reduction XOR over a zero-extended data word (up to 9 bits)
  function automatic logic xor9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, received word and status out.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (input uart_rx, output rx_data, rx_valid, parity_err, frame_err, rx_busy);
  modport slave  (output uart_rx, input rx_data, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_bit_sampler.sv
// Line conditioning for one UART channel: synchroniser, falling-edge detect
// and a 3-sample majority vote driven by the parent's baud strobes.
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  input  logic smp_first,
  input  logic smp_second,
  output logic start_edge,
  output logic bit_val
);

  logic sync1_r, sync2_r, dly_r, smp_a_r, smp_b_r;

  // Flops reset to the idle-high level so reset release cannot fake a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      dly_r   <= 1'b1;
      smp_a_r <= 1'b1;
      smp_b_r <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
      if (smp_first) begin
        smp_a_r <= sync2_r;
      end
      if (smp_second) begin
        smp_b_r <= sync2_r;
      end
    end
  end

  assign start_edge = dly_r & ~sync2_r;
  // Third sample is the live synchronised value, so the vote is ready at C+1
  assign bit_val    = maj3(smp_a_r, smp_b_r, sync2_r);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-voted sampling and start-bit glitch rejection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_cfg_if.master bus
);

  localparam int PERIOD = CLK_FREQ / UART_BPS;
  localparam int C      = PERIOD / 2;
  localparam int CNT_W  = cnt_width(PERIOD);

  rx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [3:0]           idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r, stop_bad_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, perr_r, ferr_r, busy_r;

  logic wrap_s, smp_a_s, smp_b_s, vote_s, start_edge_s, bit_val_s;
  logic par_xor_s, par_err_s;

  assign wrap_s  = (cnt_r == CNT_W'(PERIOD - 1));
  assign smp_a_s = (state_r != ST_IDLE) && (cnt_r == CNT_W'(C - 1));
  assign smp_b_s = (state_r != ST_IDLE) && (cnt_r == CNT_W'(C));
  assign vote_s  = (state_r != ST_IDLE) && (cnt_r == CNT_W'(C + 1));

  uart_bit_sampler u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (bus.uart_rx),
    .smp_first  (smp_a_s),
    .smp_second (smp_b_s),
    .start_edge (start_edge_s),
    .bit_val    (bit_val_s)
  );

  assign par_xor_s = xor9(9'(shift_r)) ^ par_bit_r;

  // Parity verdict for the word currently held in the shift register
  always_comb begin
    par_err_s = 1'b0;
    case (PARITY)
      PAR_ODD:  par_err_s = ~par_xor_s;
      PAR_EVEN: par_err_s = par_xor_s;
      default:  par_err_s = 1'b0;
    endcase
  end

  // Frame FSM, baud counter and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      idx_r      <= 4'd0;
      shift_r    <= '0;
      par_bit_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      cnt_r   <= wrap_s ? '0 : cnt_r + CNT_W'(1);
      case (state_r)
        ST_IDLE: begin
          cnt_r      <= '0;
          idx_r      <= 4'd0;
          stop_bad_r <= 1'b0;
          if (start_edge_s) begin
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (vote_s && bit_val_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (wrap_s) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_s) begin
            shift_r <= {bit_val_s, shift_r[DATA_BITS-1:1]};
          end
          if (wrap_s) begin
            if (idx_r == 4'(DATA_BITS - 1)) begin
              idx_r   <= 4'd0;
              state_r <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_s) begin
            par_bit_r <= bit_val_s;
          end
          if (wrap_s) begin
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave on the last stop vote so a start edge half a bit later is seen
          if (vote_s) begin
            if (!bit_val_s) begin
              stop_bad_r <= 1'b1;
            end
            if (idx_r == 4'(STOP_BITS - 1)) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
              data_r  <= shift_r;
              perr_r  <= par_err_s;
              ferr_r  <= stop_bad_r | ~bit_val_s;
            end
          end else if (wrap_s) begin
            idx_r <= idx_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data    = data_r;
  assign bus.rx_valid   = valid_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err  = ferr_r;
  assign bus.rx_busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations (8N1 at the
// default rate, 8E2 and 5O1 at fast rates) against a wire-level frame model.
module tb_uart_rx_cfg;

  typedef logic bitq_t[$];
  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rx_rec_t;

  localparam int CLK_A = 50000000, BPS_A = 115200, PER_A = CLK_A / BPS_A;
  localparam int CLK_B = 1000000,  BPS_B = 77000,  PER_B = CLK_B / BPS_B;
  localparam int CLK_C = 1000000,  BPS_C = 100000, PER_C = CLK_C / BPS_C;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rx_rec_t qa[$], qb[$], qc[$];

  uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();
  uart_rx_cfg_if #(.DATA_BITS(5)) ifc ();

  uart_rx_cfg #(.CLK_FREQ(CLK_A), .UART_BPS(BPS_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_rx_cfg #(.CLK_FREQ(CLK_B), .UART_BPS(BPS_B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  uart_rx_cfg #(.CLK_FREQ(CLK_C), .UART_BPS(BPS_C), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifa.rx_valid) qa.push_back('{data: 9'(ifa.rx_data), perr: ifa.parity_err, ferr: ifa.frame_err, cyc: cyc});
    if (ifb.rx_valid) qb.push_back('{data: 9'(ifb.rx_data), perr: ifb.parity_err, ferr: ifb.frame_err, cyc: cyc});
    if (ifc.rx_valid) qc.push_back('{data: 9'(ifc.rx_data), perr: ifc.parity_err, ferr: ifc.frame_err, cyc: cyc});
  end

  function automatic int per_of(input int d);
    case (d)
      0:       return PER_A;
      1:       return PER_B;
      default: return PER_C;
    endcase
  endfunction
  function automatic int nb_of(input int d);
    return (d == 2) ? 5 : 8;
  endfunction
  function automatic int pm_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction
  function automatic int ns_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Expected falling-edge-to-valid latency from the frame layout
  function automatic int latency(input int nb, input int pm, input int ns, input int per);
    return 3 + (nb + ((pm != 0) ? 1 : 0) + ns) * per + per / 2 + 2;
  endfunction

  // Wire bits of a frame: start, data LSB first, optional parity, stop bits
  function automatic bitq_t build_frame(input logic [8:0] d, input int nb, input int pm,
                                        input int ns, input logic pflip, input logic [1:0] sl);
    bitq_t q;
    int ones;
    logic p;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm != 0) begin
      p = (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      q.push_back(p ^ pflip);
    end
    for (int s = 0; s < ns; s++) q.push_back(~sl[s]);
    return q;
  endfunction

  // What a correct receiver reports for a given sequence of wire bits
  function automatic rx_rec_t decode(input bitq_t q, input int nb, input int pm, input int ns);
    rx_rec_t e;
    int ones, pos;
    e = '{data: 9'd0, perr: 1'b0, ferr: 1'b0, cyc: 0};
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      e.data[i] = q[1 + i];
      ones += int'(q[1 + i]);
    end
    pos = 1 + nb;
    if (pm != 0) begin
      ones += int'(q[pos]);
      e.perr = (pm == 1) ? (ones % 2 != 1) : (ones % 2 != 0);
      pos++;
    end
    for (int s = 0; s < ns; s++) if (q[pos + s] == 1'b0) e.ferr = 1'b1;
    return e;
  endfunction

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       ifa.uart_rx = v;
      1:       ifb.uart_rx = v;
      default: ifc.uart_rx = v;
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic pop_rec(input int d, output rx_rec_t r, output bit ok);
    r  = '{data: 9'd0, perr: 1'b0, ferr: 1'b0, cyc: 0};
    ok = 1'b0;
    if (qsize(d) > 0) begin
      ok = 1'b1;
      case (d)
        0:       r = qa.pop_front();
        1:       r = qb.pop_front();
        default: r = qc.pop_front();
      endcase
    end
  endtask

  // Drive bits one period each; optional 1-cycle inversion mid-bit
  task automatic drive_bits(input int d, input bitq_t bits, input int per, input int gidx);
    foreach (bits[i]) begin
      set_line(d, bits[i]);
      if (i == gidx) begin
        repeat (per / 2) @(negedge clk);
        set_line(d, ~bits[i]);
        @(negedge clk);
        set_line(d, bits[i]);
        repeat (per - per / 2 - 1) @(negedge clk);
      end else begin
        repeat (per) @(negedge clk);
      end
    end
    set_line(d, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ifa.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ifa.rx_data); end
    checks++; if (ifa.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifa.rx_valid); end
    checks++; if (ifa.parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", ifa.parity_err); end
    checks++; if (ifa.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ifa.frame_err); end
    checks++; if (ifa.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifa.rx_busy); end
    checks++; if (ifc.rx_data !== 5'h00) begin failures++; $display("FAIL reset_data_c got=%h exp=00", ifc.rx_data); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (ifa.rx_busy !== 1'b0 || ifb.rx_busy !== 1'b0) begin
      failures++; $display("FAIL release_busy got=%b%b exp=00", ifa.rx_busy, ifb.rx_busy);
    end
    checks++; if (qa.size() + qb.size() + qc.size() != 0) begin
      failures++; $display("FAIL release_valid got=%0d exp=0", qa.size() + qb.size() + qc.size());
    end
  endtask

  task automatic test_8n1();
    bitq_t bits;
    rx_rec_t r;
    bit ok;
    int f, dl;
    bits = build_frame(9'h055, 8, 0, 1, 1'b0, 2'b00);
    f = cyc;
    drive_bits(0, bits, PER_A, -1);
    repeat (20) @(negedge clk);
    checks++; if (qa.size() != 1) begin failures++; $display("FAIL 8n1_count got=%0d exp=1", qa.size()); end
    pop_rec(0, r, ok);
    checks++; if (r.data !== 9'h055) begin failures++; $display("FAIL 8n1_data got=%h exp=055", r.data); end
    checks++; if (r.perr !== 1'b0 || r.ferr !== 1'b0) begin
      failures++; $display("FAIL 8n1_flags got=%b%b exp=00", r.perr, r.ferr);
    end
    dl = r.cyc - f - latency(8, 0, 1, PER_A);
    checks++; if (!ok || dl < -1 || dl > 1) begin
      failures++; $display("FAIL 8n1_latency got=%0d exp=%0d", r.cyc - f, latency(8, 0, 1, PER_A));
    end
    checks++; if (ifa.rx_busy !== 1'b0) begin failures++; $display("FAIL 8n1_busy got=%b exp=0", ifa.rx_busy); end
  endtask

  task automatic test_parity();
    bitq_t b0, b1;
    rx_rec_t e0, e1, r;
    bit ok;
    b0 = build_frame(9'h0A3, 8, 2, 2, 1'b0, 2'b00);
    b1 = build_frame(9'h0A3, 8, 2, 2, 1'b1, 2'b00);
    e0 = decode(b0, 8, 2, 2);
    e1 = decode(b1, 8, 2, 2);
    drive_bits(1, b0, PER_B, -1);
    repeat (PER_B) @(negedge clk);
    drive_bits(1, b1, PER_B, -1);
    repeat (3 * PER_B) @(negedge clk);
    checks++; if (qb.size() != 2) begin failures++; $display("FAIL par_count got=%0d exp=2", qb.size()); end
    pop_rec(1, r, ok);
    checks++; if (r.data !== e0.data || r.perr !== e0.perr) begin
      failures++; $display("FAIL par_good got=%h/%b exp=%h/%b", r.data, r.perr, e0.data, e0.perr);
    end
    pop_rec(1, r, ok);
    checks++; if (r.data !== e1.data || r.perr !== e1.perr || r.ferr !== 1'b0) begin
      failures++; $display("FAIL par_bad got=%h/%b/%b exp=%h/%b/0", r.data, r.perr, r.ferr, e1.data, e1.perr);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = qa.size();
    set_line(0, 1'b0);
    repeat (100) @(negedge clk);
    set_line(0, 1'b1);
    repeat (50) @(negedge clk);
    checks++; if (ifa.rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_hi got=%b exp=1", ifa.rx_busy); end
    repeat (110) @(negedge clk);
    checks++; if (ifa.rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_lo got=%b exp=0", ifa.rx_busy); end
    repeat (PER_A) @(negedge clk);
    checks++; if (qa.size() != n0) begin failures++; $display("FAIL glitch_valid got=%0d exp=%0d", qa.size(), n0); end
  endtask

  task automatic test_framing();
    bitq_t b0, b1;
    rx_rec_t r;
    bit ok;
    b0 = build_frame(9'h03C, 8, 0, 1, 1'b0, 2'b01);
    b1 = build_frame(9'h03C, 8, 0, 1, 1'b0, 2'b00);
    drive_bits(0, b0, PER_A, -1);
    repeat (PER_A) @(negedge clk);
    drive_bits(0, b1, PER_A, -1);
    repeat (20) @(negedge clk);
    checks++; if (qa.size() != 2) begin failures++; $display("FAIL frm_count got=%0d exp=2", qa.size()); end
    pop_rec(0, r, ok);
    checks++; if (r.data !== 9'h03C || r.ferr !== 1'b1) begin
      failures++; $display("FAIL frm_bad got=%h/%b exp=03c/1", r.data, r.ferr);
    end
    pop_rec(0, r, ok);
    checks++; if (r.data !== 9'h03C || r.ferr !== 1'b0) begin
      failures++; $display("FAIL frm_good got=%h/%b exp=03c/0", r.data, r.ferr);
    end
  endtask

  task automatic test_back_to_back();
    rx_rec_t r;
    bit ok;
    logic [8:0] exp_d[3];
    exp_d[0] = 9'h000;
    exp_d[1] = 9'h0FF;
    exp_d[2] = 9'h000;
    drive_bits(0, build_frame(9'h000, 8, 0, 1, 1'b0, 2'b00), PER_A, -1);
    drive_bits(0, build_frame(9'h0FF, 8, 0, 1, 1'b0, 2'b00), PER_A, -1);
    drive_bits(0, build_frame(9'h000, 8, 0, 1, 1'b0, 2'b00), PER_A, 4);
    repeat (20) @(negedge clk);
    checks++; if (qa.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", qa.size()); end
    for (int i = 0; i < 3; i++) begin
      pop_rec(0, r, ok);
      checks++; if (!ok || r.data !== exp_d[i] || r.ferr !== 1'b0) begin
        failures++; $display("FAIL b2b_frame%0d got=%h/%b exp=%h/0", i, r.data, r.ferr, exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bitq_t bits;
    rx_rec_t r;
    bit ok;
    bits = build_frame(9'h05A, 8, 2, 2, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      set_line(1, bits[i]);
      repeat (PER_B) @(negedge clk);
    end
    set_line(1, bits[5]);
    repeat (PER_B / 2) @(negedge clk);
    checks++; if (ifb.rx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_pre got=%b exp=1", ifb.rx_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (ifb.rx_busy !== 1'b0 || ifb.rx_data !== 8'h00) begin
      failures++; $display("FAIL rstmid_async got=%b/%h exp=0/00", ifb.rx_busy, ifb.rx_data);
    end
    set_line(1, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * PER_B) @(negedge clk);
    checks++; if (qb.size() != 0) begin failures++; $display("FAIL rstmid_novalid got=%0d exp=0", qb.size()); end
    drive_bits(1, build_frame(9'h081, 8, 2, 2, 1'b0, 2'b00), PER_B, -1);
    repeat (3 * PER_B) @(negedge clk);
    pop_rec(1, r, ok);
    checks++; if (!ok || r.data !== 9'h081 || r.ferr !== 1'b0 || r.perr !== 1'b0) begin
      failures++; $display("FAIL rstmid_frame got=%b/%h/%b/%b exp=1/081/0/0", ok, r.data, r.ferr, r.perr);
    end
  endtask

  task automatic test_break();
    bitq_t zeros;
    rx_rec_t e, r;
    bit ok;
    for (int i = 0; i < 8; i++) zeros.push_back(1'b0);
    e = decode(zeros, 5, 1, 1);
    set_line(2, 1'b0);
    repeat (24 * PER_C) @(negedge clk);
    set_line(2, 1'b1);
    repeat (3 * PER_C) @(negedge clk);
    checks++; if (qc.size() != 1) begin failures++; $display("FAIL break_count got=%0d exp=1", qc.size()); end
    pop_rec(2, r, ok);
    checks++; if (r.data !== e.data || r.ferr !== e.ferr || r.perr !== e.perr) begin
      failures++; $display("FAIL break_frame got=%h/%b/%b exp=%h/%b/%b", r.data, r.ferr, r.perr, e.data, e.ferr, e.perr);
    end
  endtask

  task automatic test_random(input int d, input int n);
    rx_rec_t exp_q[$];
    rx_rec_t e, r;
    bitq_t bits;
    bit ok;
    int per, nb, pm, ns, gap, gidx, dl;
    logic [8:0] dv;
    logic pflip;
    logic [1:0] sl;
    per = per_of(d); nb = nb_of(d); pm = pm_of(d); ns = ns_of(d);
    for (int k = 0; k < n; k++) begin
      dv    = 9'($urandom_range(0, (1 << nb) - 1));
      pflip = (pm != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sl[0] = ($urandom_range(0, 3) == 32'd0);
      sl[1] = (ns == 2) && ($urandom_range(0, 3) == 32'd0);
      gidx  = ($urandom_range(0, 3) == 32'd0) ? int'($urandom_range(1, nb)) : -1;
      bits  = build_frame(dv, nb, pm, ns, pflip, sl);
      e     = decode(bits, nb, pm, ns);
      e.cyc = cyc + latency(nb, pm, ns, per);
      exp_q.push_back(e);
      drive_bits(d, bits, per, gidx);
      // A low stop bit needs some idle high before the next start edge
      gap = (sl != 2'b00) ? int'($urandom_range(4, 2 * per)) : int'($urandom_range(0, 2 * per));
      repeat (gap) @(negedge clk);
    end
    repeat (3 * per) @(negedge clk);
    checks++; if (qsize(d) != exp_q.size()) begin
      failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", d, qsize(d), exp_q.size());
    end
    foreach (exp_q[i]) begin
      pop_rec(d, r, ok);
      dl = r.cyc - exp_q[i].cyc;
      checks++; if (!ok || r.data !== exp_q[i].data || r.perr !== exp_q[i].perr || r.ferr !== exp_q[i].ferr) begin
        failures++; $display("FAIL rnd%0d_frame%0d got=%h/%b/%b exp=%h/%b/%b", d, i,
                             r.data, r.perr, r.ferr, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
      end
      checks++; if (!ok || dl < -1 || dl > 1) begin
        failures++; $display("FAIL rnd%0d_latency%0d got=%0d exp=%0d", d, i, r.cyc, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    ifa.uart_rx = 1'b1;
    ifb.uart_rx = 1'b1;
    ifc.uart_rx = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_break();
    test_random(1, 25);
    test_random(2, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
